// File: rtl/instr_encoder_loader_if.sv
// Field stream and instruction-memory write port of instr_encoder_loader.
// master = field source / memory side, slave = the loader.
interface instr_encoder_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_kind;
    logic [2:0]        in_funct3;
    logic              in_funct7b5;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [31:0]       in_imm;
    logic              in_last;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    modport master (
        output in_valid, in_kind, in_funct3, in_funct7b5, in_rd, in_rs1, in_rs2, in_imm, in_last,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_kind, in_funct3, in_funct7b5, in_rd, in_rs1, in_rs2, in_imm, in_last,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// Encodes symbolic RV32I fields into instruction words and writes them to consecutive IMEM addresses.
// Optional macro ENC_RANGE_CHECK_EN: out-of-range immediates become a NOP and raise err.
module instr_encoder_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    instr_encoder_loader_if.slave  bus,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_W:0]        count,
    output logic                   err
);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [31:0]       NOP       = 32'h0000_0013;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_e;
    typedef enum logic [2:0] {
        K_R      = 3'd0,
        K_I      = 3'd1,
        K_LOAD   = 3'd2,
        K_STORE  = 3'd3,
        K_BRANCH = 3'd4,
        K_JAL    = 3'd5
    } kind_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              err_q, err_d;

    kind_e       kind;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic        f7b5;
    logic        is_shift;
    logic [31:0] enc_word;
    logic        kind_err;
    logic        range_err;
    logic        accept;

    assign kind     = kind_e'(bus.in_kind);
    assign imm      = bus.in_imm;
    assign f3       = bus.in_funct3;
    assign rd       = bus.in_rd;
    assign rs1      = bus.in_rs1;
    assign rs2      = bus.in_rs2;
    assign f7b5     = bus.in_funct7b5;
    assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

    // NOTE: every signal assigned in an always_comb gets a default first, so no path infers a latch.
    always_comb begin
        enc_word = NOP;
        kind_err = 1'b0;
        case (kind)
            K_R:      enc_word = {1'b0, f7b5, 5'b0, rs2, rs1, f3, rd, OP_R};
            K_I: begin
                if (f3 == 3'b101) enc_word = {1'b0, f7b5, 5'b0, imm[4:0], rs1, f3, rd, OP_I};
                else              enc_word = {imm[11:0], rs1, f3, rd, OP_I};
            end
            K_LOAD:   enc_word = {imm[11:0], rs1, f3, rd, OP_LOAD};
            K_STORE:  enc_word = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
            K_BRANCH: enc_word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
            K_JAL:    enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
            default:  kind_err = 1'b1;
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    // A signed N-bit field fits when imm[31:N-1] is pure sign extension.
    always_comb begin
        range_err = 1'b0;
        case (kind)
            K_I: begin
                if (is_shift) range_err = (imm[31:5] != '0);
                else          range_err = !((imm[31:11] == '0) || (imm[31:11] == '1));
            end
            K_LOAD, K_STORE: range_err = !((imm[31:11] == '0) || (imm[31:11] == '1));
            K_BRANCH:        range_err = !((imm[31:12] == '0) || (imm[31:12] == '1)) || imm[0];
            K_JAL:           range_err = !((imm[31:20] == '0) || (imm[31:20] == '1)) || imm[0];
            default:         range_err = 1'b0;
        endcase
    end
`else
    logic unused_imm;
    assign range_err  = 1'b0;
    assign unused_imm = ^{imm[31:21], imm[0], is_shift};
`endif

    assign accept = (state_q == S_LOAD) && bus.in_valid;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        count_d   = count_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_LOAD;
                    addr_d  = BASE;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = (kind_err || range_err) ? NOP : enc_word;
                    addr_d    = addr_q + 1'b1;
                    count_d   = count_q + 1'b1;
                    err_d     = err_q | kind_err | range_err;
                    // The top address is the last one ever written; never wrap back to 0.
                    if (bus.in_last || (addr_q == LAST_ADDR)) state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: reset is synchronous and also clears wr_en_q, so a write accepted in the reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            addr_q    <= BASE;
            count_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= BASE;
            wr_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            count_q   <= count_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            err_q     <= err_d;
        end
    end

    assign bus.in_ready = (state_q == S_LOAD);
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign busy         = (state_q == S_LOAD) || wr_en_q;
    assign done         = (state_q == S_DONE);
    assign count        = count_q;
    assign err          = err_q;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: vector table plus scoreboarded write port,
// with a second ADDR_W=2 instance for the address-exhaustion case.
module tb_instr_encoder_loader;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       start4 = 1'b0;
    logic       busy, done, err;
    logic [8:0] count;
    logic       busy4, done4, err4;
    logic [2:0] count4;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    instr_encoder_loader_if #(.ADDR_W(8)) bus ();
    instr_encoder_loader_if #(.ADDR_W(2)) bus4 ();

    instr_encoder_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut (
        .clk(clk), .reset(reset), .start(start), .bus(bus.slave),
        .busy(busy), .done(done), .count(count), .err(err)
    );

    instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .bus(bus4.slave),
        .busy(busy4), .done(done4), .count(count4), .err(err4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]  kind;
        logic [2:0]  f3;
        logic        f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        int          wcyc;
    } exp_t;

    exp_t       sbq[$];
    exp_t       sbq4[$];
    logic [7:0] exp_addr = '0;
    vec_t       vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.wr_en === 1'b1) begin
            if (sbq.size() == 0) check("unexpected_write", 32'd1, 32'd0);
            else begin
                e = sbq.pop_front();
                check("wr_addr", {24'd0, bus.wr_addr}, {24'd0, e.addr});
                check("wr_data", bus.wr_data, e.data);
                check("wr_cycle", cyc, e.wcyc);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (bus4.wr_en === 1'b1) begin
            if (sbq4.size() == 0) check("unexpected_write4", 32'd1, 32'd0);
            else begin
                e = sbq4.pop_front();
                check("wr_addr4", {30'd0, bus4.wr_addr}, {24'd0, e.addr});
                check("wr_data4", bus4.wr_data, e.data);
                check("wr_cycle4", cyc, e.wcyc);
            end
        end
    end

    task automatic send(input vec_t v, input logic last);
        logic ok;
        bus.in_kind     = v.kind;
        bus.in_funct3   = v.f3;
        bus.in_funct7b5 = v.f7;
        bus.in_rd       = v.rd;
        bus.in_rs1      = v.rs1;
        bus.in_rs2      = v.rs2;
        bus.in_imm      = v.imm;
        bus.in_last     = last;
        bus.in_valid    = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 16 && !ok; t++) begin
            if (bus.in_ready === 1'b1) begin
                sbq.push_back('{exp_addr, v.exp, cyc + 1});
                exp_addr++;
                ok = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        exp_addr = '0;
    endtask

    task automatic drain();
        for (int t = 0; t < 8 && sbq.size() != 0; t++) begin
            @(posedge clk); #1;
        end
        check("drain", sbq.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   accepted;
        int   sent;

        //          kind  f3    f7    rd  rs1 rs2 imm            expected word
        vecs[0] = '{3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0,        32'h002081B3};
        vecs[1] = '{3'd0, 3'd0, 1'b1, 5'd5, 5'd6, 5'd7, 32'd0,        32'h407302B3};
        vecs[2] = '{3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFF00093};
        vecs[3] = '{3'd1, 3'd5, 1'b1, 5'd2, 5'd3, 5'd0, 32'd4,        32'h4041D113};
        vecs[4] = '{3'd2, 3'd2, 1'b0, 5'd4, 5'd2, 5'd0, 32'd12,       32'h00C12203};
        vecs[5] = '{3'd3, 3'd2, 1'b0, 5'd0, 5'd2, 5'd5, 32'd8,        32'h00512423};
        vecs[6] = '{3'd4, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 32'hFE000EE3};
        vecs[7] = '{3'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8,        32'h008000EF};
        vecs[8] = '{3'd4, 3'd1, 1'b0, 5'd0, 5'd1, 5'd2, 32'd16,       32'h00209863};
        vecs[9] = '{3'd5, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFF8, 32'hFF9FF06F};

        bus.in_valid = 1'b0; bus.in_kind = '0; bus.in_funct3 = '0; bus.in_funct7b5 = 1'b0;
        bus.in_rd = '0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_imm = '0; bus.in_last = 1'b0;
        bus4.in_valid = 1'b0; bus4.in_kind = '0; bus4.in_funct3 = '0; bus4.in_funct7b5 = 1'b0;
        bus4.in_rd = '0; bus4.in_rs1 = '0; bus4.in_rs2 = '0; bus4.in_imm = '0; bus4.in_last = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_wr_en", bus.wr_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_count", count, 0);
        check("rst_wr_addr", bus.wr_addr, 0);
        check("rst_wr_data", bus.wr_data, 0);
        check("rst4_count", count4, 0);
        reset = 1'b0;

        // Valid without start in IDLE must not be accepted
        bus.in_valid = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        check("idle_in_ready", bus.in_ready, 0);
        bus.in_valid = 1'b0;

        // Session A: full table back-to-back, start pulse mid-session ignored
        pulse_start();
        check("load_in_ready", bus.in_ready, 1);
        check("load_busy", busy, 1);
        for (int i = 0; i < 10; i++) begin
            start = (i == 3);
            send(vecs[i], i == 9);
            start = 1'b0;
        end
        check("last_done", done, 1);
        check("last_in_ready", bus.in_ready, 0);
        drain();
        check("a_done", done, 1);
        check("a_busy", busy, 0);
        check("a_in_ready", bus.in_ready, 0);
        check("a_count", count, 10);
        check("a_err", err, 0);

        // Session B: single JAL with in_last, then out-of-range I-ALU immediate
        pulse_start();
        check("b_done_cleared", done, 0);
        check("b_count_cleared", count, 0);
        send(vecs[7], 1'b1);
        drain();
        check("b_done", done, 1);
        check("b_busy", busy, 0);
        check("b_count", count, 1);

        pulse_start();
`ifdef ENC_RANGE_CHECK_EN
        v = '{3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h00000013};
`else
        v = '{3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h80000093};
`endif
        send(v, 1'b1);
        drain();
`ifdef ENC_RANGE_CHECK_EN
        check("range_err", err, 1);
`else
        check("range_err", err, 0);
`endif
        check("range_count", count, 1);

        // Session C: illegal kind becomes NOP and sets sticky err
        pulse_start();
        check("c_err_cleared", err, 0);
        v = '{3'd7, 3'd2, 1'b1, 5'd9, 5'd4, 5'd6, 32'd100, 32'h00000013};
        send(v, 1'b0);
        send(vecs[0], 1'b1);
        drain();
        check("kind_err", err, 1);
        check("kind_count", count, 2);
        pulse_start();
        check("err_cleared_by_start", err, 0);

        // Reset in the accept cycle drops the pending write
        bus.in_kind = 3'd0; bus.in_funct3 = 3'd0; bus.in_funct7b5 = 1'b0;
        bus.in_rd = 5'd3; bus.in_rs1 = 5'd1; bus.in_rs2 = 5'd2; bus.in_imm = '0;
        bus.in_valid = 1'b1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.in_valid = 1'b0;
        check("rmid_wr_en", bus.wr_en, 0);
        check("rmid_done", done, 0);
        check("rmid_count", count, 0);
        check("rmid_busy", busy, 0);
        check("rmid_in_ready", bus.in_ready, 0);
        @(posedge clk); #1;
        check("rmid_wr_en2", bus.wr_en, 0);
        pulse_start();
        send(vecs[1], 1'b1);
        drain();
        check("rmid_resume_count", count, 1);

        // ADDR_W=2 instance: five valid inputs, only four addresses exist
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        accepted = 0;
        sent = 0;
        for (int t = 0; t < 10; t++) begin
            bus4.in_valid = (sent < 5);
            bus4.in_kind  = 3'd0;
            bus4.in_rd    = 5'(sent + 1);
            if (bus4.in_valid && bus4.in_ready === 1'b1) begin
                sbq4.push_back('{8'(accepted), (32'(sent + 1) << 7) | 32'h33, cyc + 1});
                accepted++;
                sent++;
            end
            @(posedge clk); #1;
        end
        bus4.in_valid = 1'b0;
        check("a4_accepted", accepted, 4);
        check("a4_done", done4, 1);
        check("a4_in_ready", bus4.in_ready, 0);
        check("a4_count", count4, 4);
        check("a4_busy", busy4, 0);
        check("a4_drain", sbq4.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
